// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one data memory between the CPU port (0)
// and a host/loader port (1); read data returns to the winner with fixed latency.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Port 1 wins when alone, or under contention when port 0 went last.
                    sel_d   = req1 & (~req0 | ~last_q);
                    we_d    = sel_d ? we1 : we0;
                    addr_d  = sel_d ? addr1 : addr0;
                    wdata_d = sel_d ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                last_d  = sel_q;
                state_d = we_q ? IDLE : RDATA;
            end
            RDATA: begin
                if (sel_q) begin
                    rdata1_d  = mem_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_cs    = (state_q == ACCESS);
        mem_we    = mem_cs & we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        gnt0      = mem_cs & ~sel_q;
        gnt1      = mem_cs & sel_q;
        busy      = (state_q != IDLE);
        rvalid0   = rvalid0_q;
        rvalid1   = rvalid1_q;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences and a
// randomized run scored against a transaction-level timeline model.
module tb_mem_arbiter;

    logic       clk, reset, req0, req1, we0, we1;
    logic [3:0] addr0, addr1, mem_addr;
    logic [7:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_cs, mem_we, busy;
    logic       mem_clr;
    logic [7:0] mem [16];
    int         total = 0;
    int         bad = 0;

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic       rst_n, r0, w0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       r1, w1;
        logic [3:0] a1;
        logic [7:0] d1;
    } in_t;

    typedef struct packed {
        logic       bus, g0, g1, v0, v1, cs, we, busy;
        logic [3:0] addr;
        logic [7:0] wdata, rd0, rd1;
    } ex_t;

    typedef struct packed {
        in_t in;
        ex_t ex;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t fi(logic rst_n, logic r0, logic w0, logic [3:0] a0, logic [7:0] d0,
                               logic r1, logic w1, logic [3:0] a1, logic [7:0] d1);
        in_t v;
        v.rst_n = rst_n; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        return v;
    endfunction

    function automatic ex_t e_base(logic [7:0] rd0, logic [7:0] rd1);
        ex_t e;
        e = '0;
        e.rd0 = rd0;
        e.rd1 = rd1;
        return e;
    endfunction

    function automatic ex_t e_rst();
        ex_t e;
        e = '0;
        e.bus = 1'b1;
        return e;
    endfunction

    function automatic ex_t e_acc(logic p, logic we, logic [3:0] a, logic [7:0] d,
                                  logic [7:0] rd0, logic [7:0] rd1);
        ex_t e;
        e = e_base(rd0, rd1);
        e.bus = 1'b1; e.g0 = ~p; e.g1 = p; e.cs = 1'b1; e.we = we; e.busy = 1'b1;
        e.addr = a; e.wdata = d;
        return e;
    endfunction

    function automatic ex_t e_rdat(logic [7:0] rd0, logic [7:0] rd1);
        ex_t e;
        e = e_base(rd0, rd1);
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic ex_t e_rv(logic p, logic [7:0] rd0, logic [7:0] rd1);
        ex_t e;
        e = e_base(rd0, rd1);
        e.v0 = ~p; e.v1 = p;
        return e;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input in_t v);
        reset = v.rst_n;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic cmp(input string t, input ex_t e);
        check({t, " gnt0"}, 8'(gnt0), 8'(e.g0));
        check({t, " gnt1"}, 8'(gnt1), 8'(e.g1));
        check({t, " rvalid0"}, 8'(rvalid0), 8'(e.v0));
        check({t, " rvalid1"}, 8'(rvalid1), 8'(e.v1));
        check({t, " mem_cs"}, 8'(mem_cs), 8'(e.cs));
        check({t, " busy"}, 8'(busy), 8'(e.busy));
        check({t, " rdata0"}, rdata0, e.rd0);
        check({t, " rdata1"}, rdata1, e.rd1);
        if (e.bus) begin
            check({t, " mem_we"}, 8'(mem_we), 8'(e.we));
            check({t, " mem_addr"}, 8'(mem_addr), 8'(e.addr));
            check({t, " mem_wdata"}, mem_wdata, e.wdata);
        end
    endtask

    task automatic do_write(input logic p, input logic [3:0] a, input logic [7:0] d);
        if (p) drv(fi(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, a, d));
        else   drv(fi(1'b1, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 4'h0, 8'h00));
        tick();
        check("wr gnt", 8'(p ? gnt1 : gnt0), 8'h01);
        check("wr mem_we", 8'(mem_we), 8'h01);
        check("wr mem_addr", 8'(mem_addr), 8'(a));
        check("wr mem_wdata", mem_wdata, d);
        drv(fi(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
        tick();
        check("wr busy", 8'(busy), 8'h00);
    endtask

    // Random-phase model state
    logic [7:0] mm [16];
    int         gc[2], rc[2];
    int         acc_c, idle_from, cyc;
    logic       pend[2], pw[2];
    logic [3:0] pa[2];
    logic [7:0] pd[2], rvd[2], erd[2];
    logic       lastp, w, ewe;
    logic [3:0] ea;
    logic [7:0] ed;

    initial begin
        in_t idle, rst_both, cont, cont_rst;
        idle     = fi(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        rst_both = fi(1'b0, 1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 1'b1, 4'h2, 8'h22);
        cont     = fi(1'b1, 1'b1, 1'b1, 4'h4, 8'h06, 1'b1, 1'b1, 4'hB, 8'h0A);
        cont_rst = cont;
        cont_rst.rst_n = 1'b0;

        for (int i = 0; i < 3; i++) tbl.push_back('{rst_both, e_rst()});
        tbl.push_back('{fi(1'b1, 1'b1, 1'b1, 4'h6, 8'hF7, 1'b0, 1'b0, 4'h0, 8'h00),
                        e_acc(1'b0, 1'b1, 4'h6, 8'hF7, 8'h00, 8'h00)});
        tbl.push_back('{idle, e_base(8'h00, 8'h00)});
        tbl.push_back('{fi(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00),
                        e_acc(1'b1, 1'b0, 4'h6, 8'h00, 8'h00, 8'h00)});
        tbl.push_back('{idle, e_rdat(8'h00, 8'h00)});
        tbl.push_back('{idle, e_rv(1'b1, 8'h00, 8'hF7)});
        tbl.push_back('{idle, e_base(8'h00, 8'hF7)});
        tbl.push_back('{cont_rst, e_rst()});
        for (int k = 0; k < 2; k++) begin
            tbl.push_back('{cont, e_acc(1'b0, 1'b1, 4'h4, 8'h06, 8'h00, 8'h00)});
            tbl.push_back('{cont, e_base(8'h00, 8'h00)});
            tbl.push_back('{cont, e_acc(1'b1, 1'b1, 4'hB, 8'h0A, 8'h00, 8'h00)});
            tbl.push_back('{(k == 1) ? idle : cont, e_base(8'h00, 8'h00)});
        end

        mem_clr = 1'b1;
        drv(rst_both);
        tick();
        mem_clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].in);
            tick();
            cmp($sformatf("vec%0d", i), tbl[i].ex);
        end

        // Reset lands while a port-0 read sits in RDATA.
        drv(fi(1'b1, 1'b1, 1'b0, 4'h6, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
        tick();
        check("rstrd gnt0", 8'(gnt0), 8'h01);
        check("rstrd addr", 8'(mem_addr), 8'h06);
        drv(idle);
        tick();
        check("rstrd rdata busy", 8'(busy), 8'h01);
        check("rstrd rdata cs", 8'(mem_cs), 8'h00);
        drv(fi(1'b0, 1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 1'b1, 4'h2, 8'h55));
        tick();
        check("rstrd rvalid0", 8'(rvalid0), 8'h00);
        check("rstrd cs", 8'(mem_cs), 8'h00);
        check("rstrd busy", 8'(busy), 8'h00);
        check("rstrd rdata0", rdata0, 8'h00);
        drv(fi(1'b1, 1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 1'b1, 4'h2, 8'h55));
        tick();
        check("post gnt0", 8'(gnt0), 8'h01);
        check("post gnt1", 8'(gnt1), 8'h00);
        check("post addr", 8'(mem_addr), 8'h04);
        drv(fi(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h2, 8'h55));
        tick();
        check("post rdata busy", 8'(busy), 8'h01);
        tick();
        check("post rvalid0", 8'(rvalid0), 8'h01);
        check("post rdata0", rdata0, 8'h06);
        tick();
        check("post gnt1 late", 8'(gnt1), 8'h01);
        check("post wr addr", 8'(mem_addr), 8'h02);
        check("post wr data", mem_wdata, 8'h55);
        drv(idle);
        tick();
        check("post idle", 8'(busy), 8'h00);

        // Back-to-back port-0 reads of 0xA then 0xB.
        do_write(1'b1, 4'hA, 8'h11);
        do_write(1'b1, 4'hB, 8'h22);
        drv(fi(1'b1, 1'b1, 1'b0, 4'hA, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
        tick();
        check("b2b gnt0 a", 8'(gnt0), 8'h01);
        check("b2b addr a", 8'(mem_addr), 8'h0A);
        drv(fi(1'b1, 1'b1, 1'b0, 4'hB, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
        tick();
        check("b2b T2 rvalid0", 8'(rvalid0), 8'h00);
        tick();
        check("b2b T3 rvalid0", 8'(rvalid0), 8'h01);
        check("b2b T3 rdata0", rdata0, 8'h11);
        tick();
        check("b2b T4 gnt0", 8'(gnt0), 8'h01);
        check("b2b T4 addr", 8'(mem_addr), 8'h0B);
        check("b2b T4 rvalid0", 8'(rvalid0), 8'h00);
        check("b2b T4 rdata0", rdata0, 8'h11);
        drv(idle);
        tick();
        check("b2b T5 rdata0", rdata0, 8'h11);
        check("b2b T5 rvalid0", 8'(rvalid0), 8'h00);
        tick();
        check("b2b T6 rvalid0", 8'(rvalid0), 8'h01);
        check("b2b T6 rdata0", rdata0, 8'h22);

        // Randomized run: model tracks when the arbiter is next free and who owes a grant.
        drv(fi(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
        tick();
        tick();
        for (int i = 0; i < 16; i++) mm[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            gc[p] = -10; rc[p] = -10; pend[p] = 1'b0; erd[p] = 8'h00;
            pw[p] = 1'b0; pa[p] = 4'h0; pd[p] = 8'h00; rvd[p] = 8'h00;
        end
        acc_c = -10; idle_from = 0; lastp = 1'b1;
        ewe = 1'b0; ea = 4'h0; ed = 8'h00;
        for (cyc = 0; cyc < 1500; cyc++) begin
            check("rnd gnt0", 8'(gnt0), 8'(gc[0] == cyc));
            check("rnd gnt1", 8'(gnt1), 8'(gc[1] == cyc));
            check("rnd mem_cs", 8'(mem_cs), 8'(acc_c == cyc));
            check("rnd busy", 8'(busy), 8'(cyc < idle_from));
            if (acc_c == cyc) begin
                check("rnd mem_we", 8'(mem_we), 8'(ewe));
                check("rnd mem_addr", 8'(mem_addr), 8'(ea));
                check("rnd mem_wdata", mem_wdata, ed);
            end
            for (int p = 0; p < 2; p++) if (rc[p] == cyc) erd[p] = rvd[p];
            check("rnd rvalid0", 8'(rvalid0), 8'(rc[0] == cyc));
            check("rnd rvalid1", 8'(rvalid1), 8'(rc[1] == cyc));
            check("rnd rdata0", rdata0, erd[0]);
            check("rnd rdata1", rdata1, erd[1]);

            for (int p = 0; p < 2; p++) begin
                if (gc[p] == cyc) pend[p] = 1'b0;
                if (!pend[p]) begin
                    pw[p]   = 1'($urandom_range(0, 1));
                    pa[p]   = 4'($urandom_range(0, 15));
                    pd[p]   = 8'($urandom_range(0, 255));
                    pend[p] = ($urandom_range(0, 2) == 0);
                end
            end
            drv(fi(1'b1, pend[0], pw[0], pa[0], pd[0], pend[1], pw[1], pa[1], pd[1]));

            if (cyc >= idle_from && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = ~lastp;
                else                    w = pend[1];
                lastp = w;
                gc[w] = cyc + 1;
                acc_c = cyc + 1;
                ewe = pw[w]; ea = pa[w]; ed = pd[w];
                if (pw[w]) begin
                    mm[pa[w]] = pd[w];
                    idle_from = cyc + 2;
                end else begin
                    rc[w] = cyc + 3;
                    rvd[w] = mm[pa[w]];
                    idle_from = cyc + 3;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
